// File: rtl/fv_core_pkg.sv
// fv_core_pkg: shared FSM state and requester-ID types for the data-memory arbiter.
package fv_core_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/fv_rr_arb2.sv
// fv_rr_arb2: 2-way round-robin grant; the pointer favours one requester and flips to the loser on every grant.
module fv_rr_arb2
    import fv_core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);
    logic ptr;
    always_comb begin
        gnt_id = req_id_t'(req[1] && (!req[0] || ptr));
        gnt    = en ? (gnt_id ? {req[1], 1'b0} : {1'b0, req[0]}) : 2'b00;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr <= 1'b0;
        else if (|gnt) ptr <= ~gnt_id;
endmodule

// File: rtl/fv_dmem_arbiter.sv
// fv_dmem_arbiter: arbitrates two load/store streams onto one data-memory port, one access in flight.
// Define FV_DMEM_SPLIT_EN to give each stream its own half of the memory.
module fv_dmem_arbiter
    import fv_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DMEM_SIZE  = 1024
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp0_err,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic                  resp1_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
`ifdef FV_DMEM_SPLIT_EN
    localparam logic [ADDR_WIDTH-1:0] LIMIT  = ADDR_WIDTH'(DMEM_SIZE / 2);
    localparam logic [ADDR_WIDTH-1:0] OFFSET = ADDR_WIDTH'(DMEM_SIZE / 2);
`else
    localparam logic [ADDR_WIDTH-1:0] LIMIT  = ADDR_WIDTH'(DMEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] OFFSET = '0;
`endif

    state_t                state, next_state;
    logic [1:0]            gnt;
    req_id_t               gid, owner;
    logic                  accept, oor, hit, done, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Ready is combinational, so it is masked by reset to keep all outputs low during reset.
    fv_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (state == IDLE && !reset),
        .req    ({req1_valid, req0_valid}),
        .gnt    (gnt),
        .gnt_id (gid)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        sel_addr   = gid ? req1_addr : req0_addr;
        sel_we     = gid ? req1_we : req0_we;
        sel_wdata  = gid ? req1_wdata : req0_wdata;
        accept     = |gnt;
        oor        = sel_addr >= LIMIT;
        hit        = accept && !oor;
        done       = state == WAIT && mem_rvalid;
        next_state = state;
        if (hit) next_state = WAIT;
        else if (done) next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            owner       <= 1'b0;
            resp0_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp0_rdata <= '0;
            resp1_valid <= 1'b0;
            resp1_err   <= 1'b0;
            resp1_rdata <= '0;
        end else begin
            mem_req     <= hit;
            mem_we      <= hit && sel_we;
            mem_addr    <= hit ? sel_addr + (gid ? OFFSET : ADDR_WIDTH'(0)) : '0;
            mem_wdata   <= hit ? sel_wdata : '0;
            if (accept) owner <= gid;
            resp0_valid <= (done && !owner) || (accept && oor && !gid);
            resp1_valid <= (done && owner) || (accept && oor && gid);
            resp0_err   <= accept && oor && !gid;
            resp1_err   <= accept && oor && gid;
            resp0_rdata <= (done && !owner) ? mem_rdata : '0;
            resp1_rdata <= (done && owner) ? mem_rdata : '0;
        end
    end
endmodule

// File: doc/fv_dmem_arbiter.md
FV_DMEM_ARBITER -- requirements
Module: fv_dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, load/store data width.
REQ-003 SHALL have parameter DMEM_SIZE, default 1024, data-memory size in bytes; power of two.
REQ-004 SHALL have ports: clk  in  1  clock, all logic on posedge; reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have, for n in {0,1} (0 = original stream, 1 = duplicate stream): reqN_valid in 1, reqN_ready out 1, reqN_we in 1, reqN_addr in ADDR_WIDTH, reqN_wdata in DATA_WIDTH.
REQ-006 SHALL have, for n in {0,1}: respN_valid out 1, respN_rdata out DATA_WIDTH, respN_err out 1 (address out of range).
REQ-007 SHALL have memory port: mem_req out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_rvalid in 1, mem_rdata in DATA_WIDTH.

Function
REQ-008 SHALL implement FSM states IDLE and WAIT.
REQ-009 SHALL, in IDLE, grant one valid requester per cycle; reqN_ready SHALL be 1 only for the granted requester in that cycle, and the request is accepted when reqN_valid && reqN_ready.
REQ-010 SHALL arbitrate round-robin: a 1-bit priority pointer selects the favoured requester; the pointer SHALL flip to the non-granted requester after every accepted request; reset value 0.
REQ-011 SHALL, with a single valid requester, grant it regardless of the pointer.
REQ-012 SHALL, for an in-range accepted request, assert mem_req, mem_we, mem_addr and mem_wdata for exactly one cycle (the cycle after acceptance) and enter WAIT.
REQ-013 SHALL, in WAIT, hold both reqN_ready at 0 and mem_req at 0 until mem_rvalid=1, then pulse respN_valid for the owning requester for one cycle with respN_rdata=mem_rdata and respN_err=0, and return to IDLE.
REQ-014 SHALL treat an address as out of range when addr >= DMEM_SIZE (or the split limit, REQ-021); such a request SHALL NOT assert mem_req, SHALL pulse respN_valid=1 with respN_err=1 and respN_rdata=0 one cycle after acceptance, and SHALL stay in IDLE.
REQ-015 SHALL ignore mem_rvalid in IDLE.
REQ-016 SHALL keep requester inputs unsampled while reqN_ready=0; requesters hold valid and payload until accepted.
REQ-017 SHALL drive respN_rdata=0 whenever respN_valid=0.

Reset
REQ-018 SHALL, on reset, asynchronously force FSM=IDLE, pointer=0, and all outputs to 0 (mem_*, reqN_ready, respN_*).
REQ-019 SHALL, on reset asserted during WAIT, abandon the outstanding access; no response SHALL be issued for it after reset deasserts.

Configuration
REQ-020 SHALL compile the split-address feature in only when macro FV_DMEM_SPLIT_EN is defined.
REQ-021 SHALL, with FV_DMEM_SPLIT_EN defined, range-check both streams against DMEM_SIZE/2 and drive mem_addr = req1_addr + DMEM_SIZE/2 for requester 1 (requester 0 unchanged).
REQ-022 SHALL, without FV_DMEM_SPLIT_EN, range-check both streams against DMEM_SIZE and pass addresses unmodified.

Structure
REQ-023 SHALL take the FSM state enum (IDLE, WAIT) and requester-ID type from shared package fv_core_pkg.
REQ-024 SHALL contain one sub-module, fv_rr_arb2 (2-way round-robin grant with pointer); the rest stays flat.

Verification
REQ-025 Both valid at reset release, addr 0x10 and 0x20, mem_rvalid 2 cycles after mem_req -> req0 granted first, mem_addr=0x10; resp0 returns, then req1 granted, mem_addr=0x20.
REQ-026 req0 only, read addr 0x40, mem_rdata=0xDEADBEEF -> resp0_valid one cycle pulse, rdata 0xDEADBEEF, err 0; pointer=1.
REQ-027 req1 write addr 0x400 (DMEM_SIZE=1024, no split) -> no mem_req; resp1_valid with err=1 next cycle.
REQ-028 FV_DMEM_SPLIT_EN defined, req1 addr 0x10 -> mem_addr=0x210; req0 addr 0x200 -> err=1, no mem_req.
REQ-029 reset asserted in WAIT, mem_rvalid pulsed after reset deasserts -> no respN_valid, FSM IDLE, all outputs 0.
REQ-030 Both valid continuously for 8 accesses -> grants alternate 0,1,0,1,...; never two mem_req without an intervening mem_rvalid.
